// File: rtl/seq_bin2bcd_if.sv
// Request/result bundle for the sequential binary-to-BCD converter.
// The master drives the request; the slave (converter) returns status and results.
interface seq_bin2bcd_if #(
    parameter int WIDTH    = 8,
    parameter int DIGITS   = 3,
    parameter int CHANNELS = 6
);
    logic                         start;
    logic [CHANNELS*WIDTH-1:0]    bin_in;
    logic                         busy;
    logic                         done;
    logic [CHANNELS*DIGITS*4-1:0] bcd_out;
    logic [CHANNELS-1:0]          ovf;

    modport master (output start, bin_in, input busy, done, bcd_out, ovf);
    modport slave  (input start, bin_in, output busy, done, bcd_out, ovf);
endinterface

// File: rtl/seq_bin2bcd.sv
// Multi-channel binary-to-BCD converter using serial shift-and-add-3,
// one bit per clock, channels converted back to back and published together.
module seq_bin2bcd #(
    parameter int WIDTH    = 8,
    parameter int DIGITS   = 3,
    parameter int CHANNELS = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    seq_bin2bcd_if.slave  bus
);
    localparam int AW = DIGITS * 4;
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    typedef enum logic [0:0] {IDLE, SHIFT} state_t;

    state_t                    state;
    logic [CHANNELS*WIDTH-1:0] snap;
    logic [CHANNELS*WIDTH-1:0] snap_sh;
    logic [WIDTH-1:0]          cur;
    logic [AW-1:0]             acc;
    logic [AW-1:0]             adj;
    logic [AW-1:0]             acc_nxt;
    logic                      ovf_pend;
    logic                      ovf_nxt;
    logic [BW-1:0]             bit_idx;
    logic [CW-1:0]             ch_idx;
    logic [CHANNELS*AW-1:0]    stage_bcd;
    logic [CHANNELS*AW-1:0]    stage_bcd_nxt;
    logic [CHANNELS-1:0]       stage_ovf;
    logic [CHANNELS-1:0]       stage_ovf_nxt;
    logic [CHANNELS*AW-1:0]    bcd_r;
    logic [CHANNELS-1:0]       ovf_r;
    logic                      busy_r;
    logic                      done_r;
    logic                      last_bit;
    logic                      last_ch;

    // Decimal correction: any digit that would become >= 10 after doubling gets +3 first.
    function automatic logic [AW-1:0] add3(input logic [AW-1:0] a);
        logic [AW-1:0] r;
        r = a;
        for (int d = 0; d < DIGITS; d++) begin
            if (a[d*4 +: 4] >= 4'd5)
                r[d*4 +: 4] = a[d*4 +: 4] + 4'd3;
        end
        return r;
    endfunction

    always_comb begin
        adj           = add3(acc);
        acc_nxt       = {adj[AW-2:0], cur[WIDTH-1]};
        ovf_nxt       = ovf_pend | adj[AW-1];
        snap_sh       = snap >> WIDTH;
        last_bit      = (bit_idx == '0);
        last_ch       = (ch_idx == CW'(CHANNELS-1));
        stage_bcd_nxt = stage_bcd;
        stage_ovf_nxt = stage_ovf;
        // Staging with the finishing channel merged in, so completion can publish all channels at once.
        for (int c = 0; c < CHANNELS; c++) begin
            if (ch_idx == CW'(c)) begin
                stage_bcd_nxt[c*AW +: AW] = acc_nxt;
                stage_ovf_nxt[c]          = ovf_nxt;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            snap      <= '0;
            cur       <= '0;
            acc       <= '0;
            ovf_pend  <= 1'b0;
            bit_idx   <= '0;
            ch_idx    <= '0;
            stage_bcd <= '0;
            stage_ovf <= '0;
            bcd_r     <= '0;
            ovf_r     <= '0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        snap     <= bus.bin_in;
                        cur      <= bus.bin_in[WIDTH-1:0];
                        acc      <= '0;
                        ovf_pend <= 1'b0;
                        ch_idx   <= '0;
                        bit_idx  <= BW'(WIDTH-1);
                        busy_r   <= 1'b1;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (!last_bit) begin
                        acc      <= acc_nxt;
                        ovf_pend <= ovf_nxt;
                        cur      <= cur << 1;
                        bit_idx  <= bit_idx - 1'b1;
                    end else begin
                        // Channel finished: stage it and reload for the next channel without a gap.
                        stage_bcd <= stage_bcd_nxt;
                        stage_ovf <= stage_ovf_nxt;
                        acc       <= '0;
                        ovf_pend  <= 1'b0;
                        bit_idx   <= BW'(WIDTH-1);
                        snap      <= snap_sh;
                        cur       <= snap_sh[WIDTH-1:0];
                        ch_idx    <= ch_idx + 1'b1;
                        if (last_ch) begin
                            bcd_r  <= stage_bcd_nxt;
                            ovf_r  <= stage_ovf_nxt;
                            done_r <= 1'b1;
                            busy_r <= 1'b0;
                            ch_idx <= '0;
                            state  <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.bcd_out = bcd_r;
    assign bus.ovf     = ovf_r;
endmodule

// File: doc/seq_bin2bcd.md
SEQ_BIN2BCD -- requirements
Module: seq_bin2bcd

Interface
REQ-001 Parameter WIDTH, default 8: bit width of each binary channel input.
REQ-002 Parameter DIGITS, default 3: number of BCD digits produced per channel.
REQ-003 Parameter CHANNELS, default 6: number of binary values converted per request.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  conversion request, sampled on the clock edge.
REQ-007 bin_in  input  CHANNELS*WIDTH  packed binary values; channel c occupies bits [c*WIDTH +: WIDTH].
REQ-008 busy  output  1  high while a conversion is in progress.
REQ-009 done  output  1  one-cycle pulse marking a new result on bcd_out/ovf.
REQ-010 bcd_out  output  CHANNELS*DIGITS*4  packed BCD; channel c at [c*DIGITS*4 +: DIGITS*4]; digit 0 (units) in the lowest nibble of the channel.
REQ-011 ovf  output  CHANNELS  per-channel flag: value did not fit in DIGITS digits.

Function
REQ-012 Conversion SHALL use the sequential shift-and-add-3 method: one input bit per clock, MSB first, channels in order 0..CHANNELS-1.
REQ-013 The FSM SHALL have states IDLE and SHIFT only.
REQ-014 In IDLE, start=1 at an edge SHALL capture all of bin_in into an internal snapshot, clear the BCD accumulator, set the channel index to 0 and the bit index to WIDTH-1, set busy=1, and enter SHIFT.
REQ-015 bin_in changes after the capture edge SHALL NOT affect the result in progress.
REQ-016 Each SHIFT edge SHALL add 3 to every accumulator digit >= 5, then shift the accumulator left one bit, inserting the current snapshot bit at bit 0.
REQ-017 The bit shifted out of the top digit SHALL be ORed into that channel's pending overflow flag.
REQ-018 After WIDTH shifts, the accumulator and overflow flag SHALL be stored in that channel's staging slot; the accumulator and bit index SHALL then reload for the next channel with no idle cycle.
REQ-019 Completion: the edge that processes the last bit of channel CHANNELS-1 SHALL update bcd_out and ovf atomically from staging, set done=1, set busy=0, and return to IDLE.
REQ-020 Latency SHALL be exactly CHANNELS*WIDTH edges from the capture edge to the completion edge (48 at defaults).
REQ-021 done SHALL stay high for exactly one cycle after the completion edge, then drop to 0.
REQ-022 bcd_out and ovf SHALL hold their last values until the next completion edge; no partial results SHALL ever be visible.
REQ-023 start while busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-024 start=1 in the cycle where done=1 (state IDLE) SHALL be accepted, giving back-to-back conversions with one IDLE cycle between them.
REQ-025 If the value exceeds 10^DIGITS-1, bcd_out SHALL hold value mod 10^DIGITS and ovf[c] SHALL be 1; otherwise ovf[c]=0.
REQ-026 Every bcd_out nibble SHALL be in 0..9 for all inputs.

Reset
REQ-027 While rst_n=0: state=IDLE, busy=0, done=0, bcd_out=0, ovf=0, and all internal counters, snapshot and staging cleared.
REQ-028 Reset asserted mid-conversion SHALL abort the conversion with no done pulse; bcd_out SHALL read 0 afterwards.
REQ-029 The first start after rst_n rises SHALL be accepted on the first edge.

Verification
REQ-030 Defaults; bin_in ch0..ch5 = 59,59,23,31,12,99; start one cycle -> after 48 edges done=1 for one cycle; bcd_out digits 059,059,023,031,012,099; ovf=0.
REQ-031 DIGITS=2; ch0=255, ch1=100, ch2=99 -> ch0 digits 55 with ovf[0]=1; ch1 digits 00 with ovf[1]=1; ch2 digits 99 with ovf[2]=0.
REQ-032 Pulse start again at cycles 5 and 20 after an accepted start; change bin_in at cycle 10 -> single done at cycle 48, result equals the values captured at the capture edge.
REQ-033 Hold start high continuously -> done pulses every 49 cycles; busy low only in the done cycles.
REQ-034 Assert rst_n=0 at cycle 30 of a conversion -> busy=0, done never pulses, bcd_out=0, ovf=0; a new start after release converts correctly.
REQ-035 Exhaustive sweep, CHANNELS=1 and WIDTH=8, values 0..255 -> bcd_out equals the decimal digits of the input; ovf=0 for all values.
